ultrasonic_echo_emulator: RTL and testbench
===========================================

// Module: ultrasonic_echo_emulator
// PURPOSE
//  Synthesizable HC-SR04 responder: accepts trig pulses from proximity_sensor and returns an
//  echo pulse whose width (in clk cycles) equals a programmed target distance.
//  Used for hardware-in-loop bring-up and LED bar-graph checks without a physical sensor.
//  Sits beside proximity_sensor in the top level: proximity_sensor.trig feeds this block,
//  and this block's echo feeds proximity_sensor.echo.
// PARAMETERS
//  TRIG_MIN_CYCLES      500        minimum trig-high width accepted (10 us @ 50 MHz)
//  BURST_CYCLES         10000      trig fall -> echo rise delay (200 us, 8x40 kHz burst)
//  ECHO_TIMEOUT_CYCLES  1900000    echo width for "no object" and clamp ceiling (38 ms)
//  HOLDOFF_CYCLES       500000     dead time after echo falls, before next trig (10 ms)
//  CNT_W                22         counter / echo_cycles width; must hold every value above
// PORTS
//  clk           in   1      system clock (CLOCK_50)
//  rst_n         in   1      asynchronous active-low reset
//  trig          in   1      trigger from initiator; asynchronous, 2-FF synchronized internally
//  echo_cycles   in   CNT_W  target echo width in clk cycles; 0 = no object
//  echo          out  1      echo pulse to initiator; registered
//  busy          out  1      high in every state except IDLE
//  trig_rejected out  1      1-cycle pulse: trig fell before TRIG_MIN_CYCLES
//  trig_ignored  out  1      1-cycle pulse: trig rising edge seen while busy
// BEHAVIOUR
//  Reset: state=IDLE; echo=0, busy=0, trig_rejected=0, trig_ignored=0; counter=0.
//   Reset mid-operation drops echo immediately (async) and returns to IDLE.
//  trig_s = trig after 2-FF sync; rise/fall = 1-cycle edges of trig_s (2-3 cycle latency).
//  FSM:
//   IDLE:     rise -> TRIG_HI, cnt=1. A level-high trig_s without a rise is ignored.
//   TRIG_HI:  trig_s high -> cnt++, saturating at TRIG_MIN_CYCLES.
//             fall with cnt>=TRIG_MIN_CYCLES -> latch len, cnt=0, BURST.
//             fall with cnt<TRIG_MIN_CYCLES -> trig_rejected=1 for one cycle, IDLE.
//   BURST:    count BURST_CYCLES cycles, then ECHO, with echo=1 on the entry cycle.
//   ECHO:     echo=1 for exactly len cycles, then echo=0, HOLDOFF.
//   HOLDOFF:  count HOLDOFF_CYCLES cycles, then IDLE.
//  len latch (sampled on the accepting fall edge only; later echo_cycles changes have no effect):
//   echo_cycles==0 or echo_cycles>ECHO_TIMEOUT_CYCLES -> len=ECHO_TIMEOUT_CYCLES;
//   otherwise len=echo_cycles.
//  Rise in BURST/ECHO/HOLDOFF: trig_ignored=1 for one cycle; no state change.
//   A trig still high on HOLDOFF->IDLE is not accepted until it goes low and rises again.
//  Rise and fall never coincide (single synchronized signal). Counters never wrap:
//   every compare is >= against a parameter, and each counter is cleared on state entry.
//  Fixed turnaround: trig_s fall -> echo rise = BURST_CYCLES cycles.
// STRUCTURE
//  hcsr04_pkg: state enum typedef (IDLE, TRIG_HI, BURST, ECHO, HOLDOFF) and default timing
//   constants at 50 MHz; proximity_sensor shares the same constants.
//  Sub-module sync_edge_detect: 2-FF synchronizer plus rise/fall pulse outputs, reset to 0.
//  The FSM and the single shared CNT_W counter live in this module.
// TESTING  (TRIG_MIN=10, BURST=20, TIMEOUT=1000, HOLDOFF=50)
//  1. echo_cycles=300, 15-cycle trig -> echo rises 20 cycles after trig_s falls, high exactly
//     300 cycles; busy falls 50 cycles after echo falls.
//  2. echo_cycles=0, and separately echo_cycles=5000 -> echo high exactly 1000 cycles each.
//  3. 5-cycle trig -> trig_rejected one pulse, echo stays 0, busy low again next cycle.
//  4. Second trig during ECHO, and again during HOLDOFF -> trig_ignored pulse each time;
//     echo width unchanged; no extra echo.
//  5. rst_n low mid-ECHO -> echo=0 the same cycle; after release a valid trig gives a normal echo.
//  6. echo_cycles changed 300->700 during BURST -> echo width 300; next measurement gives 700.

Source files
------------

// File: rtl/ultrasonic_echo_emulator_pkg.sv
// Shared HC-SR04 timing constants (50 MHz clock) and the echo emulator state type.
package ultrasonic_echo_emulator_pkg;

  localparam int TRIG_MIN_CYCLES_DEF     = 500;
  localparam int BURST_CYCLES_DEF        = 10000;
  localparam int ECHO_TIMEOUT_CYCLES_DEF = 1900000;
  localparam int HOLDOFF_CYCLES_DEF      = 500000;
  localparam int CNT_W_DEF               = 22;

  typedef enum logic [2:0] {
    IDLE,
    TRIG_HI,
    BURST,
    ECHO,
    HOLDOFF
  } state_t;

endpackage

// File: rtl/ultrasonic_echo_emulator_if.sv
// Trigger/echo link between an HC-SR04 initiator (master) and the emulator (slave).
interface ultrasonic_echo_emulator_if #(
  parameter int CNT_W = 22
);
  logic             trig;
  logic [CNT_W-1:0] echo_cycles;
  logic             echo;
  logic             busy;
  logic             trig_rejected;
  logic             trig_ignored;

  modport master (
    output trig, echo_cycles,
    input  echo, busy, trig_rejected, trig_ignored
  );

  modport slave (
    input  trig, echo_cycles,
    output echo, busy, trig_rejected, trig_ignored
  );
endinterface

// File: rtl/ultrasonic_echo_emulator_sync_edge_detect.sv
// Two-flop synchronizer for the asynchronous trig line with 1-cycle rise/fall pulses.
module ultrasonic_echo_emulator_sync_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);
  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Synchronizer chain plus one delayed copy for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise_o = sync_q & ~prev_q;
  assign fall_o = ~sync_q & prev_q;
endmodule

// File: rtl/ultrasonic_echo_emulator.sv
// HC-SR04 responder: qualifies a trig pulse, waits the burst time, then drives an echo
// pulse whose width is the programmed distance in clk cycles, followed by a dead time.
//
// state   | meaning
// IDLE    | waiting for a trig rising edge
// TRIG_HI | measuring trig high width (saturates at TRIG_MIN_CYCLES)
// BURST   | emulated 40 kHz burst, trig fall -> echo rise
// ECHO    | echo held high for the latched length
// HOLDOFF | dead time after echo, new trigs flagged as ignored
module ultrasonic_echo_emulator
  import ultrasonic_echo_emulator_pkg::*;
#(
  parameter int TRIG_MIN_CYCLES     = TRIG_MIN_CYCLES_DEF,
  parameter int BURST_CYCLES        = BURST_CYCLES_DEF,
  parameter int ECHO_TIMEOUT_CYCLES = ECHO_TIMEOUT_CYCLES_DEF,
  parameter int HOLDOFF_CYCLES      = HOLDOFF_CYCLES_DEF,
  parameter int CNT_W               = CNT_W_DEF
) (
  input logic                         clk,
  input logic                         rst_n,
  ultrasonic_echo_emulator_if.slave   sns
);
  // BURST entry cycle counts as 0 and the ECHO entry cycle is already the registered
  // echo rise, so the burst ends two counts early to give an exact trig_s-fall->echo delay.
  localparam logic [CNT_W-1:0] TRIG_MIN_C = CNT_W'(TRIG_MIN_CYCLES);
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST_CYCLES - 2);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLDOFF_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_C  = CNT_W'(ECHO_TIMEOUT_CYCLES);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             echo_q, echo_d;
  logic             rej_q, rej_d;
  logic             ign_q, ign_d;
  logic             trig_rise;
  logic             trig_fall;
  logic [CNT_W-1:0] len_sel;

  ultrasonic_echo_emulator_sync_edge_detect u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (sns.trig),
    .rise_o (trig_rise),
    .fall_o (trig_fall)
  );

  assign len_sel = ((sns.echo_cycles == '0) || (sns.echo_cycles > TIMEOUT_C))
                   ? TIMEOUT_C : sns.echo_cycles;

  // State, shared counter, latched length and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      echo_q  <= 1'b0;
      rej_q   <= 1'b0;
      ign_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      echo_q  <= echo_d;
      rej_q   <= rej_d;
      ign_q   <= ign_d;
    end
  end

  // Next-state, counter and pulse decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    echo_d  = echo_q;
    rej_d   = 1'b0;
    ign_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (trig_rise) begin
          state_d = TRIG_HI;
          cnt_d   = CNT_W'(1);
        end
      end
      TRIG_HI: begin
        if (trig_fall) begin
          cnt_d = '0;
          if (cnt_q >= TRIG_MIN_C) begin
            len_d   = len_sel;
            state_d = BURST;
          end else begin
            rej_d   = 1'b1;
            state_d = IDLE;
          end
        end else if (cnt_q < TRIG_MIN_C) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      BURST: begin
        if (cnt_q >= BURST_LAST) begin
          state_d = ECHO;
          echo_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ECHO: begin
        if (cnt_q >= len_q - CNT_W'(1)) begin
          state_d = HOLDOFF;
          echo_d  = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HOLDOFF: begin
        if (cnt_q >= HOLD_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        echo_d  = 1'b0;
      end
    endcase
    if (trig_rise && (state_q == BURST || state_q == ECHO || state_q == HOLDOFF)) begin
      ign_d = 1'b1;
    end
  end

  assign sns.echo          = echo_q;
  assign sns.busy          = (state_q != IDLE);
  assign sns.trig_rejected = rej_q;
  assign sns.trig_ignored  = ign_q;
endmodule

// File: tb/tb_ultrasonic_echo_emulator.sv
// Directed bench for ultrasonic_echo_emulator with a timestamp-based reference model.
module tb_ultrasonic_echo_emulator;
  localparam int CNT_W  = 22;
  localparam int TMIN   = 10;
  localparam int TBURST = 20;
  localparam int TTO    = 1000;
  localparam int THOLD  = 50;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ultrasonic_echo_emulator_if #(.CNT_W(CNT_W)) sns ();

  ultrasonic_echo_emulator #(
    .TRIG_MIN_CYCLES     (TMIN),
    .BURST_CYCLES        (TBURST),
    .ECHO_TIMEOUT_CYCLES (TTO),
    .HOLDOFF_CYCLES      (THOLD),
    .CNT_W               (CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sns   (sns)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic s0, s1, s2;

  // reference model: absolute cycle stamps of the expected waveform
  bit m_in_trig;
  int m_rise_cyc, m_busy_end, m_echo_rise, m_echo_fall, m_rej_at, m_ign_at;

  // observed-waveform measurements
  bit p_echo, p_busy;
  int echo_rises = 0, echo_rise_cyc = 0, echo_width = 0, busy_fall_cyc = 0;
  int rej_pulses = 0, ign_pulses = 0, trig_low_cyc = 0;

  function automatic int clamp_len(int v);
    return (v == 0 || v > TTO) ? TTO : v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_in_trig   = 1'b0;
    m_rise_cyc  = 0;
    m_busy_end  = 0;
    m_echo_rise = -1;
    m_echo_fall = -1;
    m_rej_at    = -1;
    m_ign_at    = -1;
  endtask

  task automatic model_step();
    bit ts_now, ts_prev, e_echo, e_busy;
    int len;
    ts_now  = s1;
    ts_prev = s2;
    if (!rst_n) begin
      model_reset();
      check("rst_echo", int'(sns.echo), 0);
      check("rst_busy", int'(sns.busy), 0);
      check("rst_rej", int'(sns.trig_rejected), 0);
      check("rst_ign", int'(sns.trig_ignored), 0);
      p_echo = 1'b0;
      p_busy = 1'b0;
      return;
    end
    e_echo = (cyc >= m_echo_rise) && (cyc < m_echo_fall);
    e_busy = m_in_trig || (cyc < m_busy_end);
    check("echo", int'(sns.echo), int'(e_echo));
    check("busy", int'(sns.busy), int'(e_busy));
    check("trig_rejected", int'(sns.trig_rejected), int'(cyc == m_rej_at));
    check("trig_ignored", int'(sns.trig_ignored), int'(cyc == m_ign_at));

    if (sns.echo && !p_echo) begin
      echo_rises++;
      echo_rise_cyc = cyc;
    end
    if (!sns.echo && p_echo) echo_width = cyc - echo_rise_cyc;
    if (!sns.busy && p_busy) busy_fall_cyc = cyc;
    if (sns.trig_rejected) rej_pulses++;
    if (sns.trig_ignored) ign_pulses++;
    p_echo = sns.echo;
    p_busy = sns.busy;

    if (ts_now && !ts_prev) begin
      if (!m_in_trig && cyc >= m_busy_end) begin
        m_in_trig  = 1'b1;
        m_rise_cyc = cyc;
      end else begin
        m_ign_at = cyc + 1;
      end
    end
    if (!ts_now && ts_prev && m_in_trig) begin
      m_in_trig = 1'b0;
      if (cyc - m_rise_cyc >= TMIN) begin
        len         = clamp_len(int'(sns.echo_cycles));
        m_echo_rise = cyc + TBURST;
        m_echo_fall = m_echo_rise + len;
        m_busy_end  = m_echo_fall + THOLD;
      end else begin
        m_rej_at = cyc + 1;
      end
    end
  endtask

  // one clock: record trig at the rising edge, check at the falling edge
  task automatic step();
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      s0 = 1'b0; s1 = 1'b0; s2 = 1'b0;
    end else begin
      s2 = s1; s1 = s0; s0 = sns.trig;
    end
    @(negedge clk);
    model_step();
  endtask

  task automatic run(input int k);
    repeat (k) step();
  endtask

  task automatic pulse(input int w);
    sns.trig = 1'b1;
    run(w);
    sns.trig = 1'b0;
    trig_low_cyc = cyc;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    run(4);
    while (sns.busy && k < budget) begin
      step();
      k++;
    end
    check("wait_idle_timeout", int'(sns.busy), 0);
  endtask

  task automatic wait_echo(input bit lvl, input int budget);
    int k = 0;
    while (sns.echo != lvl && k < budget) begin
      step();
      k++;
    end
    check("wait_echo_timeout", int'(sns.echo), int'(lvl));
  endtask

  initial begin
    int e0, r0, i0;
    sns.trig        = 1'b0;
    sns.echo_cycles = '0;
    rst_n = 1'b0;
    s0 = 1'b0; s1 = 1'b0; s2 = 1'b0;
    p_echo = 1'b0; p_busy = 1'b0;
    model_reset();
    run(3);
    rst_n = 1'b1;
    run(5);

    // 1: nominal 300-cycle echo
    sns.echo_cycles = CNT_W'(300);
    e0 = echo_rises;
    pulse(15);
    wait_idle(3000);
    check("t1_rise_delay", echo_rise_cyc - trig_low_cyc, 22);
    check("t1_width", echo_width, 300);
    check("t1_holdoff", busy_fall_cyc - (echo_rise_cyc + echo_width), 50);
    check("t1_echo_count", echo_rises - e0, 1);

    // 2: clamp to timeout, and a 1-cycle echo
    sns.echo_cycles = '0;
    pulse(15);
    wait_idle(3000);
    check("t2_zero_width", echo_width, 1000);
    sns.echo_cycles = CNT_W'(5000);
    pulse(15);
    wait_idle(3000);
    check("t2_big_width", echo_width, 1000);
    sns.echo_cycles = CNT_W'(1);
    pulse(15);
    wait_idle(3000);
    check("t2_one_width", echo_width, 1);

    // 3: short trigs rejected, exact minimum accepted
    e0 = echo_rises;
    r0 = rej_pulses;
    pulse(5);
    wait_idle(200);
    check("t3_rej_count", rej_pulses - r0, 1);
    check("t3_busy_drop", busy_fall_cyc - trig_low_cyc, 3);
    check("t3_no_echo", echo_rises - e0, 0);
    pulse(9);
    wait_idle(200);
    check("t3_rej9_count", rej_pulses - r0, 2);
    pulse(10);
    wait_idle(3000);
    check("t3_min_accepted", echo_rises - e0, 1);
    check("t3_rej_total", rej_pulses - r0, 2);

    // 4: trigs during ECHO and HOLDOFF are flagged and change nothing
    sns.echo_cycles = CNT_W'(300);
    e0 = echo_rises;
    i0 = ign_pulses;
    pulse(15);
    wait_echo(1'b1, 200);
    run(50);
    pulse(3);
    wait_echo(1'b0, 1000);
    run(10);
    pulse(3);
    wait_idle(3000);
    check("t4_ign_count", ign_pulses - i0, 2);
    check("t4_width", echo_width, 300);
    check("t4_echo_count", echo_rises - e0, 1);
    pulse(15);
    wait_echo(1'b1, 200);
    wait_echo(1'b0, 1000);
    run(10);
    sns.trig = 1'b1;
    run(80);
    sns.trig = 1'b0;
    run(20);
    check("t4_held_ign", ign_pulses - i0, 3);
    check("t4_held_no_echo", echo_rises - e0, 2);
    check("t4_held_idle", int'(sns.busy), 0);

    // 5: asynchronous reset in the middle of ECHO
    pulse(15);
    wait_echo(1'b1, 200);
    run(100);
    rst_n = 1'b0;
    #1;
    check("t5_async_echo", int'(sns.echo), 0);
    check("t5_async_busy", int'(sns.busy), 0);
    run(3);
    rst_n = 1'b1;
    run(5);
    e0 = echo_rises;
    pulse(15);
    wait_idle(3000);
    check("t5_recover_width", echo_width, 300);
    check("t5_recover_count", echo_rises - e0, 1);

    // 6: echo_cycles change during BURST only affects the next measurement
    sns.echo_cycles = CNT_W'(300);
    pulse(15);
    run(10);
    sns.echo_cycles = CNT_W'(700);
    wait_idle(3000);
    check("t6_latched_width", echo_width, 300);
    pulse(15);
    wait_idle(3000);
    check("t6_next_width", echo_width, 700);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
